// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex-to-segment table and index-width helper for the scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low {g,f,e,d,c,b,a} segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment driver with shadow latch, LZB and ghost blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GHOST_CYC   = 64,
    parameter int LZB_EN      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [4*NUM_DIGITS-1:0]              value,
    input  logic [NUM_DIGITS-1:0]                dp_in,
    input  logic                                 load,
    input  logic                                 blank_in,
    output logic [6:0]                           seg,
    output logic                                 dp,
    output logic [NUM_DIGITS-1:0]                an,
    output logic [idx_width(NUM_DIGITS)-1:0]     digit_idx
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           presc;
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   lz;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    wrap;
    logic                    dark;

    assign wrap = presc == PW'(REFRESH_DIV - 1);
    assign dark = blank_in || presc < PW'(GHOST_CYC);
    assign nib  = sh_val[digit_idx*4 +: 4];

    seg7_hex_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // A digit above 0 is a leading zero when it and every higher nibble are zero
    always_comb begin
        lz = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            lz[i] = (sh_val >> (4*i)) == '0;
    end

    always_comb begin
        seg_n = (dark || (LZB_EN != 0 && lz[digit_idx])) ? SEG_OFF : dec_seg;
        dp_n  = dark || !sh_dp[digit_idx];
        an_n  = dark ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            digit_idx <= '0;
            sh_val    <= '0;
            sh_dp     <= '0;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
            an        <= '1;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap)
                digit_idx <= (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_in;
            end
            seg <= seg_n;
            dp  <= dp_n;
            an  <= an_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: vector table, corner sequences and randomized run against a cycle-count reference model
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_in = 1'b0;
    logic [6:0]  seg, seg2;
    logic        dp, dp2;
    logic [3:0]  an, an2;
    logic [1:0]  digit_idx, idx2;

    int vectors = 0;
    int errors  = 0;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GHOST_CYC(GC), .LZB_EN(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank_in(blank_in),
        .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GHOST_CYC(GC), .LZB_EN(0)) dut_nolzb (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank_in(blank_in),
        .seg(seg2), .dp(dp2), .an(an2), .digit_idx(idx2)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: e counts clean edges since the last reset edge, so the
    // slot phase is e % RD and the selected digit is (e / RD) % N.
    int          e = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [6:0]  e_seg = 7'h7F, e_seg2 = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_an = 4'hF;
    logic [1:0]  e_idx = '0;
    logic        chk = 1'b0;

    always @(posedge clk) begin
        int p, d;
        logic [3:0] nibv;
        logic dark, lzb;
        if (rst) begin
            e_seg = 7'h7F; e_seg2 = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_idx = '0;
            e = 0; m_val = '0; m_dp = '0; chk = 1'b1;
        end else begin
            p    = e % RD;
            d    = (e / RD) % N;
            nibv = 4'((m_val >> (4*d)) & 16'hF);
            lzb  = d > 0 && (m_val >> (4*d)) == 16'h0;
            dark = blank_in || p < GC;
            e_an   = dark ? 4'hF : ~(4'b0001 << d);
            e_seg2 = dark ? 7'h7F : hex_seg[nibv];
            e_seg  = (dark || lzb) ? 7'h7F : hex_seg[nibv];
            e_dp   = dark ? 1'b1 : !m_dp[d];
            e = e + 1;
            e_idx = 2'((e / RD) % N);
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            vectors++;
            if ({seg, dp, an, digit_idx} !== {e_seg, e_dp, e_an, e_idx} || seg2 !== e_seg2) begin
                errors++;
                $display("FAIL model t=%0t seg/dp/an/idx/seg_nolzb got=%h/%b/%h/%0d/%h exp=%h/%b/%h/%0d/%h",
                         $time, seg, dp, an, digit_idx, seg2, e_seg, e_dp, e_an, e_idx, e_seg2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [3:0]  x_an;
        logic [6:0]  x_seg;
        logic [6:0]  x_seg_nolzb;
        logic        x_dp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n;
        logic [3:0] prev;
        tbl = '{
            '{16'h12AF, 4'b0000, 4'hE, 7'h0E, 7'h0E, 1'b1},
            '{16'h12AF, 4'b0000, 4'hD, 7'h08, 7'h08, 1'b1},
            '{16'h12AF, 4'b0000, 4'hB, 7'h24, 7'h24, 1'b1},
            '{16'h12AF, 4'b0000, 4'h7, 7'h79, 7'h79, 1'b1},
            '{16'h0050, 4'b0000, 4'h7, 7'h7F, 7'h40, 1'b1},
            '{16'h0050, 4'b0000, 4'hB, 7'h7F, 7'h40, 1'b1},
            '{16'h0050, 4'b0000, 4'hD, 7'h12, 7'h12, 1'b1},
            '{16'h0050, 4'b0000, 4'hE, 7'h40, 7'h40, 1'b1},
            '{16'h0000, 4'b0100, 4'hE, 7'h40, 7'h40, 1'b1},
            '{16'h0000, 4'b0100, 4'hB, 7'h7F, 7'h40, 1'b0},
            '{16'h0000, 4'b0100, 4'hD, 7'h7F, 7'h40, 1'b1}
        };

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_dp", 32'(dp), 32'h1);
            check("rst_an", 32'(an), 32'hF);
            check("rst_idx", 32'(digit_idx), 32'h0);
        end
        rst = 1'b0;

        foreach (tbl[k]) begin
            value = tbl[k].val;
            dp_in = tbl[k].dpv;
            load  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (an !== tbl[k].x_an && n < 40);
            check($sformatf("tbl%0d_an", k), 32'(an), 32'(tbl[k].x_an));
            check($sformatf("tbl%0d_seg", k), 32'(seg), 32'(tbl[k].x_seg));
            check($sformatf("tbl%0d_seg_nolzb", k), 32'(seg2), 32'(tbl[k].x_seg_nolzb));
            check($sformatf("tbl%0d_dp", k), 32'(dp), 32'(tbl[k].x_dp));
        end

        // blank pulse starting on the first lit cycle of digit 1
        value = 16'h12AF; dp_in = '0; load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        n = 0;
        do begin
            prev = an;
            @(negedge clk);
            n++;
        end while (!(an == 4'hD && prev != 4'hD) && n < 80);
        check("blank_sync", 32'(an), 32'hD);
        blank_in = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("blank_an", 32'(an), 32'hF);
            check("blank_seg", 32'(seg), 32'h7F);
        end
        check("blank_idx_runs", 32'(digit_idx), 32'h2);
        blank_in = 1'b0;
        @(negedge clk);
        check("unblank_an", 32'(an), 32'hB);
        check("unblank_seg", 32'(seg), 32'h24);

        // load on the edge that wraps digit 3 back to digit 0
        n = 0;
        while (!(e % RD == RD - 1 && (e / RD) % N == N - 1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        value = 16'h4563; load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check("wrap_idx", 32'(digit_idx), 32'h0);
        repeat (3) @(negedge clk);
        check("wrap_an", 32'(an), 32'hE);
        check("wrap_seg", 32'(seg), 32'h30);

        // reset in the middle of a lit slot
        n = 0;
        while (an == 4'hF && n < 16) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_dp", 32'(dp), 32'h1);
        check("midrst_idx", 32'(digit_idx), 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an == 4'hF && n < 20);
        check("midrst_first_an_cycles", 32'(n), 32'(GC + 1));
        check("midrst_first_an", 32'(an), 32'hE);
        check("midrst_first_seg", 32'(seg), 32'h40);

        repeat (600) begin
            @(negedge clk);
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            load     = ($urandom % 8) == 0;
            blank_in = ($urandom % 16) == 0;
            rst      = ($urandom % 200) == 0;
        end
        @(negedge clk);
        {load, blank_in, rst} = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
